// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
package loader_pkg;
  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;
endpackage

// File: rtl/byte_lane_packer.sv
// Accumulates stream bytes into little-endian lanes of one 32-bit word, with per-lane strobes.
module byte_lane_packer
  import loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(LANES)-1:0] lane,
  input  logic [BYTE_W-1:0]        data,
  input  logic                     en,
  input  logic                     clr,
  output logic [WORD_W-1:0]        word,
  output logic [LANES-1:0]         strb
);

  // clr wins over en: the completing byte is merged by the parent, not stored here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      strb <= '0;
    end else if (clr) begin
      word <= '0;
      strb <= '0;
    end else if (en) begin
      word[lane*BYTE_W +: BYTE_W] <= data;
      strb[lane]                  <= 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream to 32-bit word writer for instruction memory, one byte per cycle,
// write issued one cycle after the byte that completes a word or ends the stream.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned SIZE      = 4 << 20,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] byte_count,
  output state_t      dbg_state
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_data/byte_last are sampled only then, and byte_ready never waits on byte_valid.

  state_t              state, state_nxt;
  logic [1:0]          lane;
  logic                accept, emit, launch, overflow;
  logic [WORD_W-1:0]   pk_word, merged_word;
  logic [LANES-1:0]    pk_strb, merged_strb;

  assign lane       = byte_count[1:0];
  assign busy       = (state == RECV);
  assign byte_ready = (state == RECV) && (byte_count < SIZE);
  assign accept     = byte_valid && byte_ready;
  assign emit       = accept && ((lane == 2'd3) || byte_last);
  assign launch     = start && (state != RECV);
  assign overflow   = (state == RECV) && byte_valid && !byte_ready;
  assign dbg_state  = state;

  byte_lane_packer u_packer (
    .clk  (clk),
    .rst  (rst),
    .lane (lane),
    .data (byte_data),
    .en   (accept),
    .clr  (launch || emit),
    .word (pk_word),
    .strb (pk_strb)
  );

  // The completing byte goes straight into the outgoing word so the buffer can clear on the same edge.
  always_comb begin
    merged_word = pk_word;
    merged_strb = pk_strb;
    merged_word[lane*BYTE_W +: BYTE_W] = byte_data;
    merged_strb[lane] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = RECV;
      RECV: begin
        if (accept && byte_last) state_nxt = DONE;
        else if (overflow)       state_nxt = ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_count <= '0;
    end else begin
      mem_we <= emit;
      if (emit) begin
        mem_waddr <= BASE_ADDR + {byte_count[31:2], 2'b00};
        mem_wdata <= merged_word;
        mem_wstrb <= merged_strb;
      end
      if (launch) begin
        byte_count <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
      end else begin
        if (accept)             byte_count <= byte_count + 32'd1;
        if (accept && byte_last) done      <= 1'b1;
        if (overflow)           err        <= 1'b1;
      end
    end
  end

endmodule
